// File: rtl/equiv_checker.sv
// Exhaustive equivalence sweeper: walks stim through every value, waits for the
// unit under test and the golden model to settle, compares their outputs and
// records mismatches.
module equiv_checker #(
    parameter int unsigned IN_W   = 10,
    parameter int unsigned CH     = 1,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_on_err,
    output logic [IN_W-1:0]  stim,
    input  logic [CH-1:0]    dut_out,
    input  logic [CH-1:0]    ref_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_valid,
    output logic [IN_W-1:0]  err_stim,
    output logic [CH-1:0]    err_mask,
    output logic [IN_W-1:0]  first_err_stim,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCompare,
        StDone
    } state_e;

    // Settle counter runs 0..SETTLE-1, so SETTLE cycles are spent in StSettle.
    localparam logic [7:0]       SettleLast = 8'(SETTLE - 1);
    localparam logic [IN_W-1:0]  StimMax    = '1;
    localparam logic [ERR_W-1:0] CntMax     = '1;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_valid_q, err_valid_d;
    logic [IN_W-1:0]  err_stim_q, err_stim_d;
    logic [CH-1:0]    err_mask_q, err_mask_d;
    logic [IN_W-1:0]  first_err_q, first_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             mismatch;
    logic [CH-1:0]    diff;
    logic [ERR_W-1:0] cnt_inc;

    assign diff     = dut_out ^ ref_out;
    assign mismatch = |diff;
    // Saturating increment so a huge error count never reads back as a pass.
    assign cnt_inc  = (err_cnt_q == CntMax) ? err_cnt_q : err_cnt_q + 1'b1;

    // Next-state and result logic for the sweep FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stop_d      = stop_q;
        stim_d      = stim_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_valid_d = 1'b0;
        err_stim_d  = err_stim_q;
        err_mask_d  = err_mask_q;
        first_err_d = first_err_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StSettle;
                    cnt_d       = '0;
                    stop_d      = stop_on_err;
                    stim_d      = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_stim_d  = '0;
                    err_mask_d  = '0;
                    first_err_d = '0;
                    err_cnt_d   = '0;
                end
            end

            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCompare;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StCompare: begin
                if (mismatch) begin
                    err_valid_d = 1'b1;
                    err_stim_d  = stim_q;
                    err_mask_d  = diff;
                    err_cnt_d   = cnt_inc;
                    // Count is still zero only before the first mismatch of the sweep.
                    if (err_cnt_q == '0) begin
                        first_err_d = stim_q;
                    end
                end
                if ((stim_q == StimMax) || (stop_q && mismatch)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = StSettle;
                    cnt_d   = '0;
                    stim_d  = stim_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            stop_q      <= 1'b0;
            stim_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_stim_q  <= '0;
            err_mask_q  <= '0;
            first_err_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stop_q      <= stop_d;
            stim_q      <= stim_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_valid_q <= err_valid_d;
            err_stim_q  <= err_stim_d;
            err_mask_q  <= err_mask_d;
            first_err_q <= first_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_valid      = err_valid_q;
    assign err_stim       = err_stim_q;
    assign err_mask       = err_mask_q;
    assign first_err_stim = first_err_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: doc/equiv_checker.md
EQUIV_CHECKER -- requirements
Module: equiv_checker

Interface
REQ-001 Parameter IN_W, default 10: width of the exhaustive stimulus vector; range 1..20.
REQ-002 Parameter CH, default 1: number of compared output channels; range 1..32.
REQ-003 Parameter SETTLE, default 2: clock cycles each vector is held before comparison; range 1..255.
REQ-004 Parameter ERR_W, default 16: width of the error counter.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: reset; asynchronous assertion and deassertion, active-low.
REQ-007 Port start, input, 1: request a sweep; sampled only in IDLE or DONE.
REQ-008 Port stop_on_err, input, 1: mode select; 1 = end the sweep at the first mismatch, 0 = full sweep; sampled with start.
REQ-009 Port stim, output, IN_W: current stimulus driven to both the DUT and the golden model.
REQ-010 Port dut_out, input, CH: outputs of the unit under test.
REQ-011 Port ref_out, input, CH: outputs of the golden model.
REQ-012 Port busy, output, 1: high while a sweep is in progress.
REQ-013 Port done, output, 1: high when a sweep has finished; held until the next start or reset.
REQ-014 Port pass, output, 1: valid while done=1; 1 when err_cnt=0.
REQ-015 Port err_valid, output, 1: one-cycle pulse per mismatching vector.
REQ-016 Port err_stim, output, IN_W: stim value of the most recent mismatch.
REQ-017 Port err_mask, output, CH: dut_out XOR ref_out of the most recent mismatch.
REQ-018 Port first_err_stim, output, IN_W: stim value of the first mismatch in the sweep.
REQ-019 Port err_cnt, output, ERR_W: count of mismatching vectors in the sweep.

Function
REQ-020 The block SHALL implement states IDLE, SETTLE, COMPARE and DONE.
REQ-021 In IDLE or DONE, start=1 at a clock edge SHALL clear err_cnt, err_stim, err_mask, first_err_stim, done and pass, set stim=0 and busy=1, latch stop_on_err, and enter SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE cycles and then enter COMPARE; stim SHALL be stable throughout SETTLE and COMPARE.
REQ-023 COMPARE SHALL last one cycle and evaluate mismatch = (dut_out != ref_out) over all CH bits.
REQ-024 On a mismatch, on the COMPARE exit edge: err_valid=1 for one cycle, err_stim<=stim, err_mask<=dut_out^ref_out, and err_cnt<=err_cnt+1, saturating at all-ones.
REQ-025 On the first mismatch of a sweep, first_err_stim<=stim; later mismatches SHALL NOT change first_err_stim.
REQ-026 Leaving COMPARE, the next state SHALL be DONE if stim is all-ones, or if the latched stop_on_err=1 and a mismatch occurred; otherwise stim<=stim+1 and the next state SHALL be SETTLE.
REQ-027 stim SHALL NOT wrap past all-ones.
REQ-028 Entering DONE SHALL set busy=0, done=1 and pass=(final err_cnt==0), including the increment from the last vector.
REQ-029 Per-vector latency SHALL be SETTLE+1 cycles; a full sweep SHALL assert done (2^IN_W)*(SETTLE+1) edges after the start edge.
REQ-030 start while busy=1 SHALL be ignored; a change of stop_on_err mid-sweep SHALL be ignored.
REQ-031 All result outputs SHALL hold their values in DONE until the next start.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE and set stim, busy, done, pass, err_valid, err_stim, err_mask, first_err_stim and err_cnt to 0, including in the middle of a sweep.
REQ-033 After rst_n deassertion, the block SHALL remain in IDLE until start=1.

Verification
REQ-034 IN_W=2, SETTLE=2, ref_out tied to dut_out, start pulse -> stim steps 0,1,2,3 every 3 cycles; done=1 and pass=1 at edge 12; err_cnt=0; no err_valid pulses.
REQ-035 IN_W=10, CH=1, dut=OR and golden=OR except golden forced wrong at stim 5 and 700, stop_on_err=0 -> two err_valid pulses; err_cnt=2; first_err_stim=5; err_stim=700; err_mask=1; pass=0.
REQ-036 Same stimulus with stop_on_err=1 -> done after vector 5; stim=5; err_cnt=1; busy=0 at (5+1)*3 edges after start.
REQ-037 CH=4 with mismatches on bits 1 and 3 at stim 9 -> err_mask=4'b1010; err_stim=9.
REQ-038 rst_n pulsed low mid-sweep at stim=100 -> all outputs 0 at once; start after release -> sweep restarts at stim=0.
REQ-039 ERR_W=2 with all vectors mismatching -> err_cnt saturates at 3; start pulsed during busy has no effect.
